// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA sync generator slice:
//   - default 640x480 timing (visible/porch/sync widths and totals)
//   - rgb_t pixel type and the colour driven during blanking
//   - cnt_width(): counter width needed to hold 0..modulus-1
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [7:0] rgb_t;

  localparam rgb_t BLANK_RGB = 8'h00;

  // A modulus of 1 still needs a one-bit register.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
// Bundles the frame-buffer read port and the VGA pin outputs.
//   PIX_RD      read strobe to the frame buffer (one HCLK wide)
//   PIX_ADDR    linear raster read address
//   PIX_DATA    read data, valid one HCLK after PIX_RD
//   HSYNC/VSYNC active-low syncs
//   RGB         pixel colour, DE visible-pixel flag
//   FRAME_START one-HCLK pulse when pixel (0,0) reaches the pins
// master: the sync generator; slave: the frame buffer / monitor side.
interface vga_sync_gen_if #(
  parameter int ADDR_W = 19
);
  import vga_pkg::*;

  logic              PIX_RD;
  logic [ADDR_W-1:0] PIX_ADDR;
  rgb_t              PIX_DATA;
  logic              HSYNC;
  logic              VSYNC;
  rgb_t              RGB;
  logic              DE;
  logic              FRAME_START;

  modport master (
    input  PIX_DATA,
    output PIX_RD, PIX_ADDR, HSYNC, VSYNC, RGB, DE, FRAME_START
  );

  modport slave (
    output PIX_DATA,
    input  PIX_RD, PIX_ADDR, HSYNC, VSYNC, RGB, DE, FRAME_START
  );

endinterface

// File: rtl/vga_timing_counter.sv
// vga_timing_counter
// Modulo-MODULUS counter used for the horizontal and vertical raster
// position.
//   clk    system clock
//   clr    synchronous clear (highest priority)
//   inc    advance by one when high
//   count  current position, 0..MODULUS-1
//   wrap   high in the cycle where inc moves count from MODULUS-1 to 0
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = 800,
  parameter int W       = cnt_width(MODULUS)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  // Combinational so the next counter in the chain advances on the same edge.
  assign wrap = inc && (count == W'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// VGA transmitter: walks the raster, fetches one byte per visible pixel
// from a synchronous-read frame buffer and drives HSYNC/VSYNC/RGB/DE.
//   HCLK    system clock
//   HRESET  synchronous active-high reset (wins over EN)
//   EN      run enable; low freezes the whole raster
//   bus     vga_sync_gen_if master: frame-buffer read port and VGA pins
// Pins show raster position (h,v) two pixel ticks after the counters
// hold it: stage 1 issues the read and decodes sync, stage 2 drives pins.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int ADDR_W    = 19
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic           EN,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int DW      = cnt_width(CLK_DIV);

  logic [DW-1:0]     div;
  logic              pix_ce;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              h_wrap;
  logic              v_wrap;
  logic              vis;
  logic              hs_now;
  logic              vs_now;
  logic [ADDR_W-1:0] addr_cnt;
  logic              hs1;
  logic              vs1;
  logic              de1;
  logic              fs1;
  logic              rd_q;
  rgb_t              pix_hold;
  rgb_t              pix_word;

  // Pixel-rate divider; it only counts while EN is high so a pause
  // resumes mid-pixel exactly where it stopped.
  assign pix_ce = EN && (div == DW'(CLK_DIV - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div <= '0;
    end else if (EN) begin
      div <= pix_ce ? '0 : div + DW'(1);
    end
  end

  vga_timing_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
    .clk   (HCLK),
    .clr   (HRESET),
    .inc   (pix_ce),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_timing_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
    .clk   (HCLK),
    .clr   (HRESET),
    .inc   (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign vis    = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
  assign hs_now = !((int'(h_cnt) >= H_VISIBLE + H_FRONT) &&
                    (int'(h_cnt) <  H_VISIBLE + H_FRONT + H_SYNC));
  assign vs_now = !((int'(v_cnt) >= V_VISIBLE + V_FRONT) &&
                    (int'(v_cnt) <  V_VISIBLE + V_FRONT + V_SYNC));

  // Read data arrives the HCLK after PIX_RD. Use it directly on that cycle
  // and keep a copy so slower pixel rates still see it at stage 2.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_q     <= 1'b0;
      pix_hold <= BLANK_RGB;
    end else begin
      rd_q <= bus.PIX_RD;
      if (rd_q) begin
        pix_hold <= bus.PIX_DATA;
      end
    end
  end

  assign pix_word = rd_q ? bus.PIX_DATA : pix_hold;

  // Two-stage pixel pipeline. The address is a running count of visible
  // pixels, cleared when the raster wraps back to (0,0).
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_cnt        <= '0;
      bus.PIX_RD      <= 1'b0;
      bus.PIX_ADDR    <= '0;
      hs1             <= 1'b1;
      vs1             <= 1'b1;
      de1             <= 1'b0;
      fs1             <= 1'b0;
      bus.HSYNC       <= 1'b1;
      bus.VSYNC       <= 1'b1;
      bus.RGB         <= BLANK_RGB;
      bus.DE          <= 1'b0;
      bus.FRAME_START <= 1'b0;
    end else begin
      bus.PIX_RD      <= pix_ce && vis;
      bus.FRAME_START <= pix_ce && fs1;
      if (pix_ce) begin
        if (vis) begin
          bus.PIX_ADDR <= addr_cnt;
        end
        if (h_wrap && v_wrap) begin
          addr_cnt <= '0;
        end else if (vis) begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
        end
        hs1       <= hs_now;
        vs1       <= vs_now;
        de1       <= vis;
        fs1       <= (h_cnt == '0) && (v_cnt == '0);
        bus.HSYNC <= hs1;
        bus.VSYNC <= vs1;
        bus.DE    <= de1;
        bus.RGB   <= de1 ? pix_word : BLANK_RGB;
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA transmitter: produces HSYNC, VSYNC and 8-bit RGB from a byte-per-pixel frame buffer.
- Drives the same pin-level interface that the VGA monitor samples in the top-level bench.
- Sits between the AHB VGA frame-buffer RAM (synchronous read port) and the VGA pins.
- Pixel rate is HCLK/CLK_DIV; default timing is 640x480 @ 800x525 totals.

Parameters:
- CLK_DIV, 2: HCLK cycles per pixel tick; must be >= 2.
- H_VISIBLE, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: HSYNC pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: VSYNC pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- ADDR_W, 19: width of the frame-buffer address; must satisfy 2^ADDR_W >= H_VISIBLE*V_VISIBLE.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous, active-high reset.
- EN  in  1  run enable; when low, pixel ticks stop and all state holds.
- PIX_RD  out  1  frame-buffer read strobe, one HCLK wide.
- PIX_ADDR  out  ADDR_W  frame-buffer read address, linear raster order.
- PIX_DATA  in  8  read data, valid exactly 1 HCLK after PIX_RD.
- HSYNC  out  1  horizontal sync, active low.
- VSYNC  out  1  vertical sync, active low.
- RGB  out  8  pixel colour; 0 during blanking.
- DE  out  1  high while RGB carries a visible pixel.
- FRAME_START  out  1  one-HCLK pulse when (h,v)=(0,0) reaches the outputs.

Behaviour:
- Reset (HRESET=1 at a HCLK edge; has priority over EN):
  - Outputs: HSYNC=1, VSYNC=1, RGB=0, DE=0, PIX_RD=0, PIX_ADDR=0, FRAME_START=0.
  - Internal: h_cnt=0, v_cnt=0, divider=0, pipeline flops cleared (inactive sync, DE=0).
- Pixel tick (pix_ce):
  - Divider counts 0..CLK_DIV-1 while EN=1; pix_ce=1 when divider==CLK_DIV-1.
  - First pix_ce occurs CLK_DIV HCLK cycles after reset release with EN=1.
- Counters, advancing on pix_ce:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL defined likewise.
  - h_cnt wraps at H_TOTAL-1 to 0; v_cnt increments on that wrap.
  - v_cnt wraps at V_TOTAL-1 to 0.
- Stage 1, registered on pix_ce from the current (h,v):
  - vis = (h<H_VISIBLE) && (v<V_VISIBLE).
  - PIX_RD = vis for exactly one HCLK, then 0.
  - PIX_ADDR = linear address; increments by 1 per visible pixel; resets to 0 at (0,0).
  - Address computed by an incrementing register, no multiplier; last address H_VISIBLE*V_VISIBLE-1 (307199 at default).
  - hs1 = !(H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC).
  - vs1 = !(V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC).
  - de1 = vis; fs1 = (h==0 && v==0).
- Stage 2, registered on the next pix_ce:
  - RGB = de1 ? PIX_DATA : 8'h00; HSYNC=hs1; VSYNC=vs1; DE=de1.
  - FRAME_START = fs1, held for one HCLK only.
- Latency: pins reflect position (h,v) exactly 2 pixel ticks after the counters hold (h,v). Sync and RGB stay mutually aligned.
- PIX_DATA is sampled only in stage 2; its value during blanking has no effect on RGB.
- EN low:
  - Divider, counters, pipeline and outputs freeze; PIX_RD forced 0.
  - On re-assertion, operation resumes at the same position with no skipped or duplicated pixel.
- Reset mid-frame: next cycle matches the reset state; the raster restarts at (0,0); PIX_ADDR restarts at 0.
- Reset and EN asserted in the same cycle: reset wins.

Decomposition:
- Package vga_pkg:
  - Default timing localparams (H_*/V_* values, H_TOTAL, V_TOTAL).
  - typedef logic [7:0] rgb_t.
  - Blank colour constant 8'h00.
- One sub-module, vga_timing_counter:
  - Parameterised modulus; inputs inc enable and sync clear; outputs count and wrap pulse.
  - Instantiated twice: horizontal (inc = pix_ce), vertical (inc = h wrap).

Test Plan:
- Reset: hold HRESET 3 cycles with EN=1 -> HSYNC=1, VSYNC=1, RGB=0, DE=0, PIX_RD=0, PIX_ADDR=0 on every cycle; first PIX_RD with PIX_ADDR=0 exactly CLK_DIV=2 HCLK after release.
- Line timing: free-run one line -> HSYNC low for 96 ticks (192 HCLK); falling edge 656 ticks after FRAME_START; HSYNC period 1600 HCLK; DE high 640 ticks per visible line.
- Frame timing: run 2 frames -> VSYNC low for 2 lines (3200 HCLK), starting 490 lines after FRAME_START; FRAME_START period 840000 HCLK; PIX_ADDR peaks at 307199, then next read is 0.
- Data path: memory model returns PIX_DATA = PIX_ADDR[7:0], and 8'hFF when not reading -> RGB equals addr[7:0] of the pixel read 2 ticks earlier; RGB=0 across all 160 blank ticks of each line.
- Pause: drop EN for 37 HCLK at h=300, v=10 -> all outputs constant during the pause; sequence resumes with next PIX_ADDR = 10*640+301 = 6701; no gap in the pixel sequence.
- Mid-frame reset: assert HRESET at v=200 -> reset values next cycle; after release FRAME_START reappears 2 ticks after restart; PIX_ADDR restarts at 0.
